seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised, multi-cycle shift-add multiplier that forms a full 2×WIDTH product from two WIDTH-bit operands, with optional two's-complement mode and an overflow flag for callers that only keep the low WIDTH bits. It is the next generation of the combinational 8-bit multiplier used by the ALU's MUL path. It trades the single-cycle adder tree for one partial product per clock behind a START/BUSY/DONE handshake. The ALU control stalls the pipeline on BUSY.

## Interface
- WIDTH, 8: operand width in bits, ≥ 2; product is 2×WIDTH.
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE.
- SIGNED_MODE  input  1  1 = two's-complement operands, 0 = unsigned; sampled with START.
- DATA1  input  WIDTH  multiplicand; sampled with START.
- DATA2  input  WIDTH  multiplier; sampled with START.
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse: PRODUCT/OVERFLOW updated.
- PRODUCT  output  2×WIDTH  full product, held until next DONE.
- OVERFLOW  output  1  high half is not the zero/sign extension of PRODUCT[WIDTH-1:0].

## Operation
- States: IDLE, CALC, FIX.
- IDLE with START=1:
  - Capture |DATA1| and |DATA2| (magnitudes if signed mode, else raw).
  - Capture neg = sign1 XOR sign2 (0 if unsigned).
  - Clear accumulator and counter; go to CALC.
- CALC, each cycle:
  - If multiplier LSB = 1, add the shifted multiplicand into the 2×WIDTH accumulator.
  - Shift the multiplicand left and the multiplier right; counter++.
  - After WIDTH steps, go to FIX.
- FIX:
  - PRODUCT ← neg ? −acc : acc, as a 2×WIDTH two's-complement negate.
  - Compute OVERFLOW from the new PRODUCT. Unsigned: high half ≠ 0. Signed: high half ≠ {WIDTH{PRODUCT[WIDTH-1]}}.
  - Pulse DONE; go to IDLE.
- Magnitude of the most-negative operand (e.g. −128) is 2^(WIDTH−1). It fits in WIDTH unsigned bits, so no special case is needed.
- START in CALC or FIX is ignored. There is no queueing and no abort.
- Counter width is clog2(WIDTH+1). Arithmetic is purely in unsigned magnitudes; the sign is applied only in FIX.

## Timing
- Reset (asynchronous assert, any state): state IDLE, BUSY=0, DONE=0, PRODUCT=0, OVERFLOW=0, internal registers 0.
- Reset mid-operation discards the operation; no DONE follows.
- START high at capture edge t0:
  - BUSY=1 from after t0.
  - Accumulate steps occur at edges t0+1 … t0+WIDTH.
  - At edge t0+WIDTH+1, PRODUCT, OVERFLOW and DONE=1 appear and BUSY=0.
- Latency: WIDTH+1 cycles from capture edge to DONE (9 for WIDTH=8).
- DONE is high for exactly one cycle. The FSM is in IDLE during that cycle, so a START then is accepted, giving back-to-back throughput of one result per WIDTH+2 cycles.
- Operand changes after the capture edge have no effect.
- BUSY and DONE are never high together.

## Configuration
- MULT_SIGNED_EN defined:
  - SIGNED_MODE is honoured.
  - Magnitude-conversion and negate logic are present.
  - OVERFLOW uses the signed rule when SIGNED_MODE=1.
- MULT_SIGNED_EN undefined:
  - SIGNED_MODE is ignored and all operations are unsigned.
  - neg is tied 0, no negate logic; OVERFLOW uses the unsigned rule.
  - Timing is identical.

## Test plan
- WIDTH=8, unsigned, 12×13: DONE 9 cycles after capture, PRODUCT=0x009C, OVERFLOW=0, BUSY low with DONE.
- Unsigned 255×255: PRODUCT=0xFE01, OVERFLOW=1. Then START during DONE cycle with 0×77: PRODUCT=0x0000, OVERFLOW=0.
- MULT_SIGNED_EN defined, SIGNED_MODE=1:
  - −3×5 (0xFD, 0x05): PRODUCT=0xFFF1, OVERFLOW=0.
  - −128×−128: PRODUCT=0x4000, OVERFLOW=1.
- MULT_SIGNED_EN undefined, SIGNED_MODE=1, 0xFD×0x05: PRODUCT=0x04F1, OVERFLOW=1.
- START re-pulsed with new operands at cycle 3 of CALC: ignored, original product delivered at the original DONE time.
- RESET low at cycle 4 of CALC: all outputs 0 immediately, no DONE. After release, a fresh 7×6 yields 0x002A. Repeat with WIDTH=16: 0xFFFF×0x0002 = 0x0001FFFE after 17 cycles.

Source files
------------

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier: one partial product per clock, WIDTH+1 cycles per result.
// Define MULT_SIGNED_EN to honour SIGNED_MODE (two's-complement operands); otherwise all operations are unsigned.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               SIGNED_MODE,
  input  logic [WIDTH-1:0]   DATA1,
  input  logic [WIDTH-1:0]   DATA2,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] PRODUCT,
  output logic               OVERFLOW
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]         state_q,    state_d;
  logic [2*WIDTH-1:0] mcand_q,    mcand_d;
  logic [WIDTH-1:0]   mplier_q,   mplier_d;
  logic [2*WIDTH-1:0] acc_q,      acc_d;
  logic [CW-1:0]      cnt_q,      cnt_d;
  logic [2*WIDTH-1:0] product_q,  product_d;
  logic               overflow_q, overflow_d;
  logic               done_q,     done_d;

  // Operand magnitudes at capture, and the signed result / overflow in FIX.
  logic [WIDTH-1:0]   mag1, mag2;
  logic [2*WIDTH-1:0] result;
  logic               result_ovf;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;
  logic sgn_q, sgn_d;
  logic sign1, sign2;

  always_comb begin
    sign1      = SIGNED_MODE & DATA1[WIDTH-1];
    sign2      = SIGNED_MODE & DATA2[WIDTH-1];
    mag1       = sign1 ? -DATA1 : DATA1;
    mag2       = sign2 ? -DATA2 : DATA2;
    neg_d      = neg_q;
    sgn_d      = sgn_q;
    if (state_q == IDLE && START) begin
      neg_d = sign1 ^ sign2;
      sgn_d = SIGNED_MODE;
    end
    result     = neg_q ? -acc_q : acc_q;
    result_ovf = sgn_q ? (result[2*WIDTH-1:WIDTH] != {WIDTH{result[WIDTH-1]}})
                       : (result[2*WIDTH-1:WIDTH] != '0);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      neg_q <= 1'b0;
      sgn_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
      sgn_q <= sgn_d;
    end
  end
`else
  logic unused_signed_mode;
  assign unused_signed_mode = SIGNED_MODE;

  always_comb begin
    mag1       = DATA1;
    mag2       = DATA2;
    result     = acc_q;
    result_ovf = (result[2*WIDTH-1:WIDTH] != '0);
  end
`endif

  always_comb begin
    // NOTE: every next-state signal starts as a hold of its flop so no path leaves it unassigned (no latches).
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          mcand_d  = {{WIDTH{1'b0}}, mag1};
          mplier_d = mag2;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        product_d  = result;
        overflow_d = result_ovf;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values computed above.
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign BUSY     = (state_q != IDLE);
  assign DONE     = done_q;
  assign PRODUCT  = product_q;
  assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: 8-bit and 16-bit instances against an arithmetic reference model.
// Expected signed-mode results follow whether MULT_SIGNED_EN is defined for the build.
module tb_seq_multiplier;

`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START8, SM8;
  logic [7:0]  A8, B8;
  logic        BUSY8, DONE8, OV8;
  logic [15:0] P8;
  logic        START16, SM16;
  logic [15:0] A16, B16;
  logic        BUSY16, DONE16, OV16;
  logic [31:0] P16;

  int n_pass = 0;
  int n_total = 0;
  int busy_gap = 0;
  int overlap = 0;

  always #5 CLK = ~CLK;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RESET(RESET), .START(START8), .SIGNED_MODE(SM8),
    .DATA1(A8), .DATA2(B8), .BUSY(BUSY8), .DONE(DONE8),
    .PRODUCT(P8), .OVERFLOW(OV8)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .CLK(CLK), .RESET(RESET), .START(START16), .SIGNED_MODE(SM16),
    .DATA1(A16), .DATA2(B16), .BUSY(BUSY16), .DONE(DONE16),
    .PRODUCT(P16), .OVERFLOW(OV16)
  );

  // Reference: integer product of the operands as numbers, truncated to 2w bits.
  function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                input bit sm, output longint unsigned p, output bit ov);
    longint sa, sb, pr;
    bit use_s;
    use_s = sm & SIGNED_EN;
    sa = longint'(a);
    sb = longint'(b);
    if (use_s && a >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
    if (use_s && b >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
    pr = sa * sb;
    p = $unsigned(pr) & ((64'd1 << (2 * w)) - 64'd1);
    if (use_s) ov = (pr < -(longint'(1) << (w - 1))) || (pr >= (longint'(1) << (w - 1)));
    else       ov = (pr >= (longint'(1) << w));
  endfunction

  // Launch one 8-bit operation; returns at the negedge where DONE is seen (or the bound expires).
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit sm, input bit imm,
                      output int lat);
    if (!imm) @(negedge CLK);
    START8 = 1'b1; SM8 = sm; A8 = a; B8 = b;
    @(negedge CLK);
    START8 = 1'b0; A8 = 8'($urandom); B8 = 8'($urandom); SM8 = 1'($urandom);
    lat = 0;
    while (DONE8 !== 1'b1 && lat < 40) begin
      if (BUSY8 !== 1'b1) busy_gap++;
      @(negedge CLK);
      lat++;
    end
    if (BUSY8 === 1'b1 && DONE8 === 1'b1) overlap++;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit sm, output int lat);
    @(negedge CLK);
    START16 = 1'b1; SM16 = sm; A16 = a; B16 = b;
    @(negedge CLK);
    START16 = 1'b0; A16 = 16'($urandom); B16 = 16'($urandom);
    lat = 0;
    while (DONE16 !== 1'b1 && lat < 60) begin
      if (BUSY16 !== 1'b1) busy_gap++;
      @(negedge CLK);
      lat++;
    end
    if (BUSY16 === 1'b1 && DONE16 === 1'b1) overlap++;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    START8 = 1'b0; SM8 = 1'b0; A8 = '0; B8 = '0;
    START16 = 1'b0; SM16 = 1'b0; A16 = '0; B16 = '0;
    #1;
    n_total++;
    if ({BUSY8, DONE8, OV8, P8} !== 19'd0)
      $display("FAIL reset8: got busy=%b done=%b ovf=%b prod=%h, want all 0", BUSY8, DONE8, OV8, P8);
    else n_pass++;
    n_total++;
    if ({BUSY16, DONE16, OV16, P16} !== 35'd0)
      $display("FAIL reset16: got busy=%b done=%b ovf=%b prod=%h, want all 0", BUSY16, DONE16, OV16, P16);
    else n_pass++;
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_unsigned_basic();
    int lat;
    run8(8'd12, 8'd13, 1'b0, 1'b0, lat);
    n_total++;
    if (lat !== 9) $display("FAIL basic_latency: got %0d cycles, want 9", lat); else n_pass++;
    n_total++;
    if (P8 !== 16'h009C || OV8 !== 1'b0)
      $display("FAIL basic_12x13: got prod=%h ovf=%b, want 009c 0", P8, OV8);
    else n_pass++;
    n_total++;
    if (BUSY8 !== 1'b0) $display("FAIL basic_busy_with_done: got busy=%b, want 0", BUSY8); else n_pass++;
    @(negedge CLK);
    n_total++;
    if (DONE8 !== 1'b0 || P8 !== 16'h009C)
      $display("FAIL basic_done_pulse: got done=%b prod=%h, want 0 009c", DONE8, P8);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    run8(8'hFF, 8'hFF, 1'b0, 1'b0, lat);
    n_total++;
    if (P8 !== 16'hFE01 || OV8 !== 1'b1 || lat !== 9)
      $display("FAIL b2b_255x255: got prod=%h ovf=%b lat=%0d, want fe01 1 9", P8, OV8, lat);
    else n_pass++;
    run8(8'h00, 8'h77, 1'b0, 1'b1, lat);
    n_total++;
    if (P8 !== 16'h0000 || OV8 !== 1'b0 || lat !== 9)
      $display("FAIL b2b_0x77: got prod=%h ovf=%b lat=%0d, want 0000 0 9", P8, OV8, lat);
    else n_pass++;
  endtask

  task automatic test_signed_mode();
    int lat;
    logic [15:0] exp_p;
    logic exp_ov;
    exp_p  = SIGNED_EN ? 16'hFFF1 : 16'h04F1;
    exp_ov = SIGNED_EN ? 1'b0 : 1'b1;
    run8(8'hFD, 8'h05, 1'b1, 1'b0, lat);
    n_total++;
    if (P8 !== exp_p || OV8 !== exp_ov || lat !== 9)
      $display("FAIL signed_m3x5: got prod=%h ovf=%b lat=%0d, want %h %b 9", P8, OV8, lat, exp_p, exp_ov);
    else n_pass++;
    run8(8'h80, 8'h80, 1'b1, 1'b0, lat);
    n_total++;
    if (P8 !== 16'h4000 || OV8 !== 1'b1)
      $display("FAIL signed_m128sq: got prod=%h ovf=%b, want 4000 1", P8, OV8);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge CLK);
    START8 = 1'b1; SM8 = 1'b0; A8 = 8'd200; B8 = 8'd3;
    @(negedge CLK);
    START8 = 1'b0;
    lat = 0;
    while (DONE8 !== 1'b1 && lat < 40) begin
      if (lat == 3) begin
        START8 = 1'b1; A8 = 8'd9; B8 = 8'd9;
      end else START8 = 1'b0;
      @(negedge CLK);
      lat++;
    end
    START8 = 1'b0;
    n_total++;
    if (P8 !== 16'd600 || OV8 !== 1'b1 || lat !== 9)
      $display("FAIL start_ignored: got prod=%h ovf=%b lat=%0d, want 0258 1 9", P8, OV8, lat);
    else n_pass++;
    @(negedge CLK);
    n_total++;
    if (BUSY8 !== 1'b0) $display("FAIL start_ignored_idle: got busy=%b, want 0", BUSY8); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int stray;
    @(negedge CLK);
    START8 = 1'b1; SM8 = 1'b0; A8 = 8'hAB; B8 = 8'hCD;
    @(negedge CLK);
    START8 = 1'b0;
    repeat (4) @(negedge CLK);
    RESET = 1'b0;
    #1;
    n_total++;
    if ({BUSY8, DONE8, OV8, P8} !== 19'd0)
      $display("FAIL midreset_clear: got busy=%b done=%b ovf=%b prod=%h, want all 0", BUSY8, DONE8, OV8, P8);
    else n_pass++;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    stray = 0;
    repeat (14) begin
      @(negedge CLK);
      if (DONE8 !== 1'b0 || BUSY8 !== 1'b0) stray++;
    end
    n_total++;
    if (stray !== 0) $display("FAIL midreset_no_done: got %0d active cycles, want 0", stray); else n_pass++;
    run8(8'd7, 8'd6, 1'b0, 1'b0, lat);
    n_total++;
    if (P8 !== 16'h002A || OV8 !== 1'b0 || lat !== 9)
      $display("FAIL midreset_7x6: got prod=%h ovf=%b lat=%0d, want 002a 0 9", P8, OV8, lat);
    else n_pass++;
  endtask

  task automatic test_random8();
    int lat;
    logic [7:0] a, b;
    bit sm;
    longint unsigned ep;
    bit eov;
    for (int i = 0; i < 24; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      sm = 1'($urandom);
      if (i == 0) a = 8'h80;
      if (i == 1) b = 8'h00;
      model(8, 64'(a), 64'(b), sm, ep, eov);
      run8(a, b, sm, (i % 3) == 2, lat);
      n_total++;
      if (P8 !== ep[15:0] || OV8 !== eov || lat !== 9)
        $display("FAIL rand8_%0d: %h*%h sm=%b got prod=%h ovf=%b lat=%0d, want %h %b 9",
                 i, a, b, sm, P8, OV8, lat, ep[15:0], eov);
      else n_pass++;
    end
  endtask

  task automatic test_width16();
    int lat;
    logic [15:0] a, b;
    bit sm;
    longint unsigned ep;
    bit eov;
    run16(16'hFFFF, 16'h0002, 1'b0, lat);
    n_total++;
    if (P16 !== 32'h0001FFFE || OV16 !== 1'b1 || lat !== 17)
      $display("FAIL w16_ffffx2: got prod=%h ovf=%b lat=%0d, want 0001fffe 1 17", P16, OV16, lat);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      sm = 1'($urandom);
      model(16, 64'(a), 64'(b), sm, ep, eov);
      run16(a, b, sm, lat);
      n_total++;
      if (P16 !== ep[31:0] || OV16 !== eov || lat !== 17)
        $display("FAIL rand16_%0d: %h*%h sm=%b got prod=%h ovf=%b lat=%0d, want %h %b 17",
                 i, a, b, sm, P16, OV16, lat, ep[31:0], eov);
      else n_pass++;
    end
  endtask

  task automatic test_handshake();
    n_total++;
    if (busy_gap !== 0) $display("FAIL busy_gap: got %0d non-busy cycles before DONE, want 0", busy_gap);
    else n_pass++;
    n_total++;
    if (overlap !== 0) $display("FAIL busy_done_overlap: got %0d, want 0", overlap); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_back_to_back();
    test_signed_mode();
    test_start_ignored();
    test_reset_mid_op();
    test_random8();
    test_width16();
    test_handshake();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
